// File: rtl/cnt_10s_ctrl.sv
// -----------------------------------------------------------------------------
// cnt_10s_ctrl
//
// Initiator side of the 10-second interval interface. Drives en_cnt_10s into
// the 10 s counter and watches its cnt_out_10s level. One accepted start runs
// repeat_n back-to-back intervals. Between intervals the enable is dropped so
// the counter can clear its output (GAP), then re-armed. A watchdog bounds the
// time spent waiting in RUN (for cnt_out_10s=1) and in GAP (for
// cnt_out_10s=0); when it expires the block parks in ERR with a sticky
// err_timeout until a new start or an abort.
//
// Handshake with the counter: en_cnt_10s is a registered level. While it is
// high the counter runs and eventually raises cnt_out_10s, holding it high
// for as long as the enable stays high. One edge with the enable low clears
// the counter output. The controller only ever samples cnt_out_10s on clk_out.
//
// Optional build macro: CNT10S_CTRL_STATUS_EN
//   defined   -> done_cnt port and saturating completed-interval counter exist
//   undefined -> done_cnt port and register are absent
//
// Ports:
//   clk_out      in   1 s period clock (single clock domain with the counter)
//   rst_n        in   asynchronous active-low reset
//   start        in   request pulse, honoured only in IDLE or ERR
//   repeat_n     in   number of intervals, latched on an accepted start
//   abort        in   cancel the current operation
//   cnt_out_10s  in   counter output level, high = interval elapsed
//   en_cnt_10s   out  registered enable to the 10 s counter
//   busy         out  high while in RUN or GAP
//   done         out  one-cycle pulse after the last interval
//   err_timeout  out  sticky watchdog error
//   rep_left     out  intervals still outstanding
//   done_cnt     out  total completed intervals (macro builds only)
// -----------------------------------------------------------------------------
module cnt_10s_ctrl #(
  parameter int REP_W    = 8,
  parameter int WDOG_W   = 5,
  parameter int WDOG_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk_out,
  input  logic             rst_n,
  input  logic             start,
  input  logic [REP_W-1:0] repeat_n,
  input  logic             abort,
  input  logic             cnt_out_10s,
  output logic             en_cnt_10s,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [REP_W-1:0] rep_left
`ifdef CNT10S_CTRL_STATUS_EN
  ,
  output logic [CNT_W-1:0] done_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_GAP  = 3'd2,
    ST_FIN  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // Last watchdog value before the timeout fires; a wait that has already
  // spent WDOG_MAX-1 edges without an answer trips on the next sampled edge.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);
  localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

  // State register and registered outputs. state_q is kept as a named enum
  // so checkers and waveform viewers can bind to it directly.
  state_e            state_q,    state_d;
  logic              en_q,       en_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              err_q,      err_d;
  logic [REP_W-1:0]  rep_left_q, rep_left_d;
  logic [WDOG_W-1:0] wdog_q,     wdog_d;

  // High for the edge on which an interval is counted (RUN exit via
  // cnt_out_10s=1, not pre-empted by abort).
  logic              interval_hit;

  logic              start_ok;
  assign start_ok = start && (repeat_n != '0);

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    rep_left_d   = rep_left_q;
    wdog_d       = wdog_q;
    interval_hit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d    = ST_RUN;
          en_d       = 1'b1;
          busy_d     = 1'b1;
          rep_left_d = repeat_n;
          wdog_d     = '0;
        end
      end

      ST_RUN: begin
        if (abort) begin
          // Abort wins over a coincident completion: interval not counted.
          state_d    = ST_IDLE;
          en_d       = 1'b0;
          busy_d     = 1'b0;
          rep_left_d = '0;
          wdog_d     = '0;
        end else if (cnt_out_10s) begin
          interval_hit = 1'b1;
          rep_left_d   = rep_left_q - REP_ONE;
          wdog_d       = '0;
          en_d         = 1'b0;
          if (rep_left_q == REP_ONE) begin
            state_d = ST_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
        end else if (wdog_q == WDOG_LAST) begin
          state_d = ST_ERR;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_d    = ST_IDLE;
          en_d       = 1'b0;
          busy_d     = 1'b0;
          rep_left_d = '0;
          wdog_d     = '0;
        end else if (!cnt_out_10s) begin
          // Counter has seen its low-enable edge and cleared; re-arm it.
          state_d = ST_RUN;
          en_d    = 1'b1;
          wdog_d  = '0;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = ST_ERR;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      ST_FIN: begin
        // done is high for this single cycle; abort here just returns to
        // IDLE, which is where FIN goes anyway.
        state_d    = ST_IDLE;
        en_d       = 1'b0;
        busy_d     = 1'b0;
        rep_left_d = '0;
      end

      ST_ERR: begin
        if (abort) begin
          state_d    = ST_IDLE;
          err_d      = 1'b0;
          rep_left_d = '0;
        end else if (start_ok) begin
          state_d    = ST_RUN;
          en_d       = 1'b1;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          rep_left_d = repeat_n;
          wdog_d     = '0;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        en_d       = 1'b0;
        busy_d     = 1'b0;
        err_d      = 1'b0;
        rep_left_d = '0;
        wdog_d     = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rep_left_q <= '0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rep_left_q <= rep_left_d;
      wdog_q     <= wdog_d;
    end
  end

  assign en_cnt_10s  = en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign rep_left    = rep_left_q;

`ifdef CNT10S_CTRL_STATUS_EN
  // ---------------------------------------------------------------------------
  // Completed-interval counter: saturates at all-ones, cleared only by reset.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (interval_hit && (done_cnt_q != '1)) begin
      done_cnt_d = done_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q <= '0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign done_cnt = done_cnt_q;
`else
  // Without the status counter the hit strobe and CNT_W have no consumer.
  logic unused_status;
  assign unused_status = interval_hit ^ (^CNT_W);
`endif

endmodule

// File: tb/tb_cnt_10s_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cnt_10s_ctrl
//
// Directed bench for cnt_10s_ctrl with a behavioural 10 s counter. Edge 0 is
// the clk_out rising edge that samples an accepted start; all observations
// are taken 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_cnt_10s_ctrl;

  localparam int REP_W = 8;
  localparam int CNT_W = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk_out = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_out = ~clk_out;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic             start    = 1'b0;
  logic [REP_W-1:0] repeat_n = '0;
  logic             abort    = 1'b0;
  logic             cnt_out_10s;
  logic             en_cnt_10s;
  logic             busy;
  logic             done;
  logic             err_timeout;
  logic [REP_W-1:0] rep_left;
`ifdef CNT10S_CTRL_STATUS_EN
  logic [CNT_W-1:0] done_cnt;
`endif

  cnt_10s_ctrl #(
    .REP_W   (REP_W),
    .WDOG_W  (5),
    .WDOG_MAX(15),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_out    (clk_out),
    .rst_n      (rst_n),
    .start      (start),
    .repeat_n   (repeat_n),
    .abort      (abort),
    .cnt_out_10s(cnt_out_10s),
    .en_cnt_10s (en_cnt_10s),
    .busy       (busy),
    .done       (done),
    .err_timeout(err_timeout),
    .rep_left   (rep_left)
`ifdef CNT10S_CTRL_STATUS_EN
    ,
    .done_cnt   (done_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Behavioural 10 s counter: counts while enabled, raises its output after
  // the 11th enabled edge and holds it; any low-enable edge clears it.
  // cnt_mode: 0 = model, 1 = output stuck 0, 2 = output stuck 1.
  // ---------------------------------------------------------------------------
  int   m_cnt    = 0;
  logic m_out    = 1'b0;
  int   cnt_mode = 0;

  always @(posedge clk_out) begin
    if (!en_cnt_10s) begin
      m_cnt <= 0;
      m_out <= 1'b0;
    end else if (m_cnt == 10) begin
      m_out <= 1'b1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  assign cnt_out_10s = (cnt_mode == 1) ? 1'b0 :
                       (cnt_mode == 2) ? 1'b1 : m_out;

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int pass_cnt     = 0;
  int total_cnt    = 0;
  int exp_done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_done_cnt(input string tag);
`ifdef CNT10S_CTRL_STATUS_EN
    check(tag, 32'(done_cnt), 32'(exp_done_cnt));
`else
    total_cnt = total_cnt + 0;
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk_out);
    #1;
  endtask

  // Presents a start request; returns 1 unit after edge 0.
  task automatic start_op(input logic [REP_W-1:0] n);
    start    = 1'b1;
    repeat_n = n;
    wait_edges(1);
    start    = 1'b0;
    repeat_n = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic exp_en;

    // Reset state
    wait_edges(2);
    check("rst_en", 32'(en_cnt_10s), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_rep_left", 32'(rep_left), 32'd0);
    check_done_cnt("rst_done_cnt");
    rst_n = 1'b1;
    wait_edges(2);

    // 1) Single interval
    start_op(8'd1);
    check("t1_en_e0", 32'(en_cnt_10s), 32'd1);
    check("t1_busy_e0", 32'(busy), 32'd1);
    check("t1_rep_left_e0", 32'(rep_left), 32'd1);
    for (int e = 1; e <= 11; e++) begin
      wait_edges(1);
      check($sformatf("t1_en_e%0d", e), 32'(en_cnt_10s), 32'd1);
      check($sformatf("t1_done_e%0d", e), 32'(done), 32'd0);
    end
    wait_edges(1);
    exp_done_cnt++;
    check("t1_done_e12", 32'(done), 32'd1);
    check("t1_en_e12", 32'(en_cnt_10s), 32'd0);
    check("t1_busy_e12", 32'(busy), 32'd0);
    check("t1_rep_left_e12", 32'(rep_left), 32'd0);
    check_done_cnt("t1_done_cnt");
    wait_edges(1);
    check("t1_done_e13", 32'(done), 32'd0);
    wait_edges(3);

    // 2) Three back-to-back intervals: completions at 12, 26, 40
    start_op(8'd3);
    for (int e = 1; e <= 41; e++) begin
      wait_edges(1);
      exp_en = (e < 12) || (e >= 14 && e < 26) || (e >= 28 && e < 40);
      check($sformatf("t2_en_e%0d", e), 32'(en_cnt_10s), 32'(exp_en));
      check($sformatf("t2_done_e%0d", e), 32'(done), 32'(e == 40));
      if (e == 12) begin
        check("t2_rep_left_e12", 32'(rep_left), 32'd2);
        check("t2_busy_e12", 32'(busy), 32'd1);
      end
      if (e == 26) check("t2_rep_left_e26", 32'(rep_left), 32'd1);
      if (e == 40) begin
        check("t2_rep_left_e40", 32'(rep_left), 32'd0);
        check("t2_busy_e40", 32'(busy), 32'd0);
      end
    end
    exp_done_cnt += 3;
    check_done_cnt("t2_done_cnt");
    wait_edges(3);

    // 3) Counter output stuck 0: RUN watchdog trips at edge 15
    cnt_mode = 1;
    start_op(8'd2);
    wait_edges(14);
    check("t3_err_e14", 32'(err_timeout), 32'd0);
    check("t3_busy_e14", 32'(busy), 32'd1);
    wait_edges(1);
    check("t3_err_e15", 32'(err_timeout), 32'd1);
    check("t3_en_e15", 32'(en_cnt_10s), 32'd0);
    check("t3_busy_e15", 32'(busy), 32'd0);
    check("t3_rep_left_e15", 32'(rep_left), 32'd2);
    cnt_mode = 0;
    wait_edges(5);
    check("t3_err_sticky", 32'(err_timeout), 32'd1);
    start_op(8'd1);
    check("t3_err_cleared", 32'(err_timeout), 32'd0);
    check("t3_en_restart", 32'(en_cnt_10s), 32'd1);
    check("t3_rep_left_restart", 32'(rep_left), 32'd1);
    wait_edges(12);
    exp_done_cnt++;
    check("t3_done_restart", 32'(done), 32'd1);
    wait_edges(3);

    // 4) Counter output stuck 1 after first completion: GAP watchdog
    start_op(8'd2);
    wait_edges(12);
    check("t4_rep_left_e12", 32'(rep_left), 32'd1);
    check("t4_en_e12", 32'(en_cnt_10s), 32'd0);
    exp_done_cnt++;
    cnt_mode = 2;
    wait_edges(14);
    check("t4_err_e26", 32'(err_timeout), 32'd0);
    check("t4_busy_e26", 32'(busy), 32'd1);
    wait_edges(1);
    check("t4_err_e27", 32'(err_timeout), 32'd1);
    check("t4_rep_left_e27", 32'(rep_left), 32'd1);
    check("t4_en_e27", 32'(en_cnt_10s), 32'd0);
    check("t4_busy_e27", 32'(busy), 32'd0);
    check_done_cnt("t4_done_cnt");
    // start and abort together in ERR: abort wins
    start    = 1'b1;
    repeat_n = 8'd1;
    abort    = 1'b1;
    wait_edges(1);
    start    = 1'b0;
    repeat_n = '0;
    abort    = 1'b0;
    check("t4_err_abort", 32'(err_timeout), 32'd0);
    check("t4_busy_abort", 32'(busy), 32'd0);
    check("t4_en_abort", 32'(en_cnt_10s), 32'd0);
    cnt_mode = 0;
    wait_edges(3);

    // 5) Abort coincident with completion at edge 12
    start_op(8'd2);
    wait_edges(11);
    check("t5_en_e11", 32'(en_cnt_10s), 32'd1);
    abort = 1'b1;
    wait_edges(1);
    abort = 1'b0;
    check("t5_en_e12", 32'(en_cnt_10s), 32'd0);
    check("t5_busy_e12", 32'(busy), 32'd0);
    check("t5_rep_left_e12", 32'(rep_left), 32'd0);
    check("t5_done_e12", 32'(done), 32'd0);
    wait_edges(1);
    check("t5_done_e13", 32'(done), 32'd0);
    check_done_cnt("t5_done_cnt");
    wait_edges(2);
    start_op(8'd0);
    check("t5_zero_busy", 32'(busy), 32'd0);
    check("t5_zero_en", 32'(en_cnt_10s), 32'd0);
    check("t5_zero_rep_left", 32'(rep_left), 32'd0);
    wait_edges(2);

    // 6) Asynchronous reset mid-RUN
    start_op(8'd3);
    wait_edges(5);
    check("t6_en_pre", 32'(en_cnt_10s), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_en", 32'(en_cnt_10s), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_rep_left", 32'(rep_left), 32'd0);
    exp_done_cnt = 0;
    check_done_cnt("t6_rst_done_cnt");
    #2;
    rst_n = 1'b1;
    wait_edges(3);
    start_op(8'd1);
    check("t6_en_restart", 32'(en_cnt_10s), 32'd1);
    check("t6_rep_left_restart", 32'(rep_left), 32'd1);
    wait_edges(12);
    exp_done_cnt++;
    check("t6_done", 32'(done), 32'd1);
    check_done_cnt("t6_done_cnt");
    wait_edges(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cnt_10s_ctrl.md
Name: cnt_10s_ctrl

Overview:
- Initiator side of the 10-second interval interface: drives en_cnt_10s into the 10 s counter and consumes its cnt_out_10s level.
- Runs a requested number of back-to-back 10 s intervals, re-arming the counter between intervals.
- Reports completion with a one-cycle done pulse and raises a sticky timeout error if the counter never answers.
- Shares the 1 s clock domain with the counter.

Parameters:
REP_W, 8, width of repeat request and remaining-count
WDOG_W, 5, watchdog counter width
WDOG_MAX, 15, max cycles allowed in RUN (waiting for cnt_out_10s=1) or in GAP (waiting for cnt_out_10s=0); must be < 2**WDOG_W
CNT_W, 16, width of done_cnt (optional feature)

Ports:
clk_out  in  1  1 s period clock, single clock domain
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE or ERR
repeat_n  in  REP_W  interval count, latched on accepted start
abort  in  1  cancel current operation
cnt_out_10s  in  1  level from 10 s counter; high = interval elapsed, held while enable stays high
en_cnt_10s  out  1  registered enable to 10 s counter
busy  out  1  high in RUN and GAP
done  out  1  one-cycle pulse after last interval
err_timeout  out  1  sticky watchdog error
rep_left  out  REP_W  intervals still outstanding
done_cnt  out  CNT_W  total completed intervals (only with CNT10S_CTRL_STATUS_EN)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; en_cnt_10s=0, busy=0, done=0, err_timeout=0, rep_left=0, watchdog=0, done_cnt=0.
- All outputs registered; state-derived outputs change on the edge that enters the state.
- IDLE:
  - start=1 with repeat_n!=0: rep_left<=repeat_n, watchdog<=0, go to RUN; en_cnt_10s is high after that edge.
  - start with repeat_n=0 is ignored.
- RUN (en=1):
  - cnt_out_10s sampled 1: rep_left decrements, watchdog<=0, and en_cnt_10s drops on the same edge.
    - If rep_left was 1, go to FIN.
    - Otherwise go to GAP.
  - Else if watchdog==WDOG_MAX-1: go to ERR with en=0.
  - Else watchdog increments.
- GAP (en=0): the counter needs one low-enable edge to clear its output.
  - cnt_out_10s sampled 0: watchdog<=0, go to RUN (en=1).
  - Watchdog reaches WDOG_MAX-1 while cnt_out_10s is still 1: go to ERR.
- FIN: done=1 for exactly one cycle, then IDLE. en=0, busy=0.
- ERR: err_timeout=1 (sticky), en=0, busy=0.
  - start with repeat_n!=0 clears err_timeout and enters RUN as from IDLE.
  - abort clears err_timeout and enters IDLE.
- abort=1 in RUN/GAP/FIN: next state IDLE, en=0, rep_left=0, no done pulse.
  - abort beats a simultaneous cnt_out_10s=1: that interval is not counted.
- start while busy or in FIN is ignored. start and abort together in ERR: abort wins.
- Nominal timing with standard counter, start sampled at edge 0:
  - en_cnt_10s high after edge 0.
  - cnt_out_10s high after edge 11; sampled at edge 12.
  - Each further interval adds 14 cycles (12 RUN + 2 GAP).

Optional Feature:
CNT10S_CTRL_STATUS_EN
- Defined: done_cnt port exists. Increments by 1 on every counted interval (RUN exit via cnt_out_10s=1). Saturates at all-ones. Cleared only by reset.
- Undefined: done_cnt port and register absent; all other behaviour identical.

Test Plan:
- Single interval (behavioural cnt_10s model, repeat_n=1, start at edge 0) -> en high edges 1..12, done=1 only in cycle after edge 12, rep_left=0, busy low after edge 12.
- repeat_n=3 -> completions sampled at edges 12, 26, 40; en low during edges 13-14 and 27-28; single done after edge 40; done_cnt=3 if macro on.
- cnt_out_10s stuck 0, repeat_n=2 -> err_timeout=1 and en=0 after edge 15; stays 1 until start/abort; new start clears it and en rises.
- cnt_out_10s stuck 1 after first completion, repeat_n=2 -> GAP watchdog trips, err_timeout=1 after 15 GAP cycles, rep_left=1 held.
- abort asserted at edge 12 coincident with cnt_out_10s=1 -> IDLE, no done, rep_left=0, done_cnt unchanged; start with repeat_n=0 -> no response.
- rst_n low mid-RUN (asynchronously, between edges) -> en_cnt_10s, busy, rep_left go 0 immediately; after release start works normally.
